phoenix_switch_control: RTL
===========================

Name: phoenix_switch_control

Overview:
Per-router switch controller for the Phoenix NoC. It arbitrates header requests from the five input buffers (EAST, WEST, NORTH, SOUTH, LOCAL) round-robin and computes the XY route from the header flit. It grants the route with ack_h and drives the crossbar select/enable table. An output is released when its owning buffer's sender drops.

Parameters:
TAM_FLIT, 8, flit width; header flit = {dest_x[TAM_FLIT-1:TAM_FLIT/2], dest_y[TAM_FLIT/2-1:0]}
ADDR_X, 0, this router's X coordinate (TAM_FLIT/2 bits)
ADDR_Y, 0, this router's Y coordinate (TAM_FLIT/2 bits)
NPORT, 5, port count; fixed indices EAST=0, WEST=1, NORTH=2, SOUTH=3, LOCAL=4

Ports:
clock  in  1  single router clock
reset  in  1  synchronous, active-high; sampled on posedge clock
h  in  NPORT  header request per input buffer
sender  in  NPORT  buffer-is-forwarding flag per input buffer
data  in  NPORT*TAM_FLIT  buffer head flits; port i occupies [i*TAM_FLIT +: TAM_FLIT]
ack_h  out  NPORT  one-hot routing grant to input buffer
mux_in  out  3*NPORT  per output o, bits [3o+:3] = index of the input driving it
mux_out  out  3*NPORT  per input i, bits [3i+:3] = index of the output it drives
out_busy  out  NPORT  per output: 1 = connection established (crossbar enable)

Behaviour:
- Reset: state=IDLE, rr_last=4, ack_h=0, mux_in=0, mux_out=0, out_busy=0, sender_d=0. Reset mid-operation tears down every connection immediately and drops any pending grant.
- FSM states: IDLE, ARB, ROUTE, GRANT.
- IDLE: if |h then go to ARB, else stay.
- ARB: search indices (rr_last+1 .. rr_last+5) mod 5. The first index with h=1 becomes sel, and rr_last<=sel; go to ROUTE. If no h bit is set, go to IDLE.
- ROUTE: latch the route from data[sel] (XY, unsigned compares):
  - dest_x>ADDR_X → EAST
  - dest_x<ADDR_X → WEST
  - otherwise dest_y>ADDR_Y → NORTH
  - dest_y<ADDR_Y → SOUTH
  - otherwise → LOCAL
  - If out_busy[route]=0, go to GRANT; else go to IDLE (request retried later; rr_last already advanced for fairness).
- GRANT: ack_h = one-hot(sel), combinational from state, high for exactly one cycle. At the closing edge: mux_in[route]<=sel, mux_out[sel]<=route, out_busy[route]<=1. Next state is IDLE.
- Latency: h first sampled at edge E0 (IDLE→ARB), E1 ARB→ROUTE, E2 ROUTE→GRANT. ack_h is high between E2 and E3; table updates at E3. Best case is 3 cycles per grant and one connection set up per 4 cycles.
- ack_h is never asserted in any state other than GRANT, and never more than one bit at a time.
- Release:
  - sender_d <= sender every cycle.
  - For each output o with out_busy[o]=1 and src=mux_in[o]: if sender_d[src]=1 and sender[src]=0, then out_busy[o]<=0. mux_in and mux_out keep their stale values and are ignored while not busy.
  - Release is independent of the FSM and can happen in any state, for multiple outputs in one cycle.
- Simultaneous events:
  - The ROUTE busy check uses the registered out_busy, so an output released at edge E is grantable only when ROUTE is evaluated after E.
  - A grant and a release never target the same output on one edge, because a busy output is never granted.
  - The falling-edge detect ensures the cycles between GRANT and the first sender=1 do not trigger a release.
- Two inputs may never map to one busy output. Invariant: out_busy[o]=1 implies mux_out[mux_in[o]]=o.

Test Plan:
1. ADDR=(1,1); LOCAL h=1, data[4]=8'h21 from E0 → ack_h=5'b10000 only between E2 and E3; at E3 mux_in[EAST]=4, mux_out[LOCAL]=0, out_busy=5'b00001.
2. Continue 1: sender[4]=1 for 6 cycles then 0 → out_busy[0] clears on the edge after sender falls; then a new LOCAL request to EAST is granted.
3. Contention: WEST and NORTH both h=1, headers 8'h11 (→LOCAL), rr_last=4 → WEST granted first. NORTH goes ARB→ROUTE→IDLE repeatedly with no ack_h until WEST's sender falls, then NORTH is granted (mux_in[LOCAL]=2).
4. Round-robin: EAST/WEST/NORTH h=1 with headers 8'h21/8'h01/8'h12 → grant order 0,1,2 at 4-cycle spacing; out_busy=5'b00111 (EAST, WEST, NORTH).
5. XY decode, ADDR=(1,1), single LOCAL requests: 8'h10→SOUTH(3), 8'h12→NORTH(2), 8'h01→WEST(1), 8'h11→LOCAL(4).
6. Assert reset for 1 cycle while state=GRANT with two outputs busy → next cycle ack_h=0, out_busy=0, state IDLE; a re-asserted h gets its grant 3 cycles later, and the search starts from EAST.

Source files
------------

// File: rtl/phoenix_switch_control.sv
// phoenix_switch_control
//   Per-router switch controller for the Phoenix NoC. Arbitrates header
//   requests from the five input buffers round-robin, computes the XY route
//   from the selected header flit, grants it with a one-cycle ack_h and keeps
//   the crossbar select/enable table. A connection is torn down when the
//   sender flag of the owning input buffer falls.
//
// Ports
//   clock     router clock
//   reset     synchronous, active-high
//   h         header request per input buffer
//   sender    buffer-is-forwarding flag per input buffer
//   data      head flit per input buffer, port i at [i*TAM_FLIT +: TAM_FLIT]
//   ack_h     one-hot routing grant (GRANT state only)
//   mux_in    per output o, [3o+:3] = input driving it
//   mux_out   per input i,  [3i+:3] = output it drives
//   out_busy  per output, connection established / crossbar enable
//
// State | meaning
//   IDLE  | waiting for any header request
//   ARB   | round-robin pick of the next requesting input
//   ROUTE | XY decode of the picked header, busy check of the target output
//   GRANT | ack_h to the picked input, crossbar table written at exit edge
module phoenix_switch_control #(
  parameter int TAM_FLIT = 8,
  parameter int ADDR_X   = 0,
  parameter int ADDR_Y   = 0,
  parameter int NPORT    = 5
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NPORT-1:0]          h,
  input  logic [NPORT-1:0]          sender,
  input  logic [NPORT*TAM_FLIT-1:0] data,
  output logic [NPORT-1:0]          ack_h,
  output logic [3*NPORT-1:0]        mux_in,
  output logic [3*NPORT-1:0]        mux_out,
  output logic [NPORT-1:0]          out_busy
);

  localparam int HW = TAM_FLIT / 2;
  localparam logic [HW-1:0] MY_X = HW'(ADDR_X);
  localparam logic [HW-1:0] MY_Y = HW'(ADDR_Y);

  localparam logic [2:0] EAST  = 3'd0;
  localparam logic [2:0] WEST  = 3'd1;
  localparam logic [2:0] NORTH = 3'd2;
  localparam logic [2:0] SOUTH = 3'd3;
  localparam logic [2:0] LOCAL = 3'd4;

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_ROUTE, S_GRANT} state_t;

  state_t               state_q, state_d;
  logic [2:0]           rr_last_q, rr_last_d;
  logic [2:0]           sel_q, sel_d;
  logic [2:0]           route_q, route_d;
  logic [NPORT-1:0]     out_busy_q;
  logic [NPORT-1:0]     sender_dly_q;
  logic [3*NPORT-1:0]   mux_in_q;
  logic [3*NPORT-1:0]   mux_out_q;

  // Round-robin search starting just after the last winner.
  logic       arb_hit;
  logic [2:0] arb_sel;
  logic [2:0] cand;
  always_comb begin
    arb_hit = 1'b0;
    arb_sel = rr_last_q;
    cand    = '0;
    for (int k = 1; k <= NPORT; k++) begin
      cand = 3'((int'(rr_last_q) + k) % NPORT);
      if (!arb_hit && h[cand]) begin
        arb_hit = 1'b1;
        arb_sel = cand;
      end
    end
  end

  // XY routing of the selected header: X first, then Y, unsigned compares.
  logic [TAM_FLIT-1:0] hdr;
  logic [HW-1:0]       dest_x, dest_y;
  logic [2:0]          xy_route;
  always_comb begin
    hdr    = data[int'(sel_q)*TAM_FLIT +: TAM_FLIT];
    dest_x = hdr[TAM_FLIT-1:HW];
    dest_y = hdr[HW-1:0];
    if (dest_x > MY_X)      xy_route = EAST;
    else if (dest_x < MY_X) xy_route = WEST;
    else if (dest_y > MY_Y) xy_route = NORTH;
    else if (dest_y < MY_Y) xy_route = SOUTH;
    else                    xy_route = LOCAL;
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rr_last_q <= 3'd4;
      sel_q     <= '0;
      route_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_last_q <= rr_last_d;
      sel_q     <= sel_d;
      route_q   <= route_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    rr_last_d = rr_last_q;
    sel_d     = sel_q;
    route_d   = route_q;
    case (state_q)
      S_IDLE: if (|h) state_d = S_ARB;
      S_ARB: begin
        if (arb_hit) begin
          sel_d     = arb_sel;
          rr_last_d = arb_sel;
          state_d   = S_ROUTE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ROUTE: begin
        route_d = xy_route;
        // Busy target: drop back, rr_last already advanced so others get a turn.
        state_d = out_busy_q[xy_route] ? S_IDLE : S_GRANT;
      end
      S_GRANT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ack_h = '0;
    if (state_q == S_GRANT) ack_h[sel_q] = 1'b1;
  end

  // Crossbar table. Release uses a falling-edge detect of the owner's sender
  // so the gap between grant and the first forwarded flit does not release.
  // A busy output is never granted, so grant and release never collide.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_busy_q   <= '0;
      sender_dly_q <= '0;
      mux_in_q     <= '0;
      mux_out_q    <= '0;
    end else begin
      sender_dly_q <= sender;
      for (int o = 0; o < NPORT; o++) begin
        if (out_busy_q[o] && sender_dly_q[mux_in_q[3*o +: 3]] && !sender[mux_in_q[3*o +: 3]])
          out_busy_q[o] <= 1'b0;
      end
      if (state_q == S_GRANT) begin
        out_busy_q[route_q]          <= 1'b1;
        mux_in_q[3*route_q +: 3]     <= sel_q;
        mux_out_q[3*sel_q +: 3]      <= route_q;
      end
    end
  end

  assign out_busy = out_busy_q;
  assign mux_in   = mux_in_q;
  assign mux_out  = mux_out_q;

endmodule
